priority_irq_ctrl: RTL and testbench
====================================

PRIORITY_IRQ_CTRL -- requirements
Module: priority_irq_ctrl

Interface
REQ-001 The block SHALL have parameter N, default 8: number of request channels, legal range 2..64.
REQ-002 The block SHALL have localparam W = ceil(log2(N)), the width of the channel index.
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port req, input, N: level request lines; bit i is channel i.
REQ-006 Port mask, input, N: bit i = 1 excludes channel i from arbitration; it does not block latching.
REQ-007 Port mode, input, 1: 0 = fixed priority (highest index wins); 1 = round-robin.
REQ-008 Port ack, input, 1: consumer accepts the current grant.
REQ-009 Port valid, output, 1, registered: a grant is being presented.
REQ-010 Port id, output, W, registered: index of the granted channel.
REQ-011 Port pending, output, N, registered: sticky latched requests.
REQ-012 Port any, output, 1, combinational: OR of (pending AND NOT mask).

Function
REQ-013 Pending SHALL update every cycle: pending[i] <= (pending[i] OR req[i]) AND NOT clr[i].
REQ-014 clr[i] SHALL be 1 only in a GRANT-state cycle with ack=1 and id=i.
REQ-015 If clr[i] and req[i] are both 1 in the same cycle, set SHALL win and pending[i] stays 1.
REQ-016 The FSM SHALL have exactly two states: IDLE (valid=0) and GRANT (valid=1).
REQ-017 IDLE SHALL move to GRANT when the eligible set E = pending AND NOT mask is non-zero, loading id with the selected index on the same edge.
REQ-018 A request arriving on req SHALL be visible in pending 1 cycle later and on valid/id at the earliest 2 cycles after it is first sampled.
REQ-019 In mode 0, the selection SHALL be the highest set index of E.
REQ-020 In mode 1, the selection SHALL be the highest set index of E strictly below last, wrapping from index 0 to N-1; if only channel last is eligible, it SHALL be selected.
REQ-021 last is a W-bit register: it SHALL load id on every accepted grant and keep its value while mode=0.
REQ-022 In GRANT, id and valid SHALL hold stable until ack=1, regardless of changes to req, mask or mode.
REQ-023 GRANT with ack=1 SHALL clear pending[id] per REQ-013..015 and return to IDLE, so valid=0 in the next cycle.
REQ-024 There SHALL be at most one grant every 2 cycles; no back-to-back grants.
REQ-025 ack in IDLE SHALL be ignored and SHALL have no effect on any state.
REQ-026 In IDLE with E = 0, id SHALL hold its previous value.
REQ-027 For N not a power of two, id SHALL never exceed N-1, and round-robin wrap SHALL go to N-1.

Reset
REQ-028 While rst_n=0, independent of clk, the state SHALL be IDLE, valid=0, id=0, pending=0 and last=0.
REQ-029 A reset asserted during GRANT SHALL drop the grant immediately, with no clr applied and no ack required.
REQ-030 req sampled in the first clock edge after rst_n rises SHALL be latched normally.

Verification
REQ-031 Fixed priority, N=8, mode=0, mask=0: req=8'b0010_0101 for 1 cycle, ack held high. Required: grants with id = 5, 2, 0 in order, valid high every other cycle, pending = 0 after the third grant.
REQ-032 Round-robin, mode=1, req held at 8'b1000_0011, ack held high. Required: id sequence 7, 1, 0, 7, 1, 0, because the set-wins rule keeps each granted bit pending.
REQ-033 Masking: pending=8'b1000_0001 and mask=8'b1000_0000. Required: id=0 is granted. Then clear mask while in IDLE. Required: next grant id=7. Also: setting mask bit 7 during a GRANT of 7 does not drop valid.
REQ-034 Handshake stall: a grant is held with ack=0 for 5 cycles while req changes. Required: valid=1 and id unchanged throughout; on the ack cycle only that pending bit clears.
REQ-035 Async reset: pull rst_n low mid-GRANT between clock edges. Required: valid=0, id=0 and pending=0 immediately, with no clk edge needed.
REQ-036 Non-power-of-two: N=5, mode=1, last=0, E=5'b10000. Required: id=4.

Source files
------------

// File: rtl/priority_irq_ctrl.sv
// Interrupt controller: sticky pending latches feeding a fixed-priority or
// round-robin arbiter that presents one grant at a time under a valid/ack handshake.
module priority_irq_ctrl #(
    parameter int unsigned N = 8,
    localparam int unsigned W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic [N-1:0] mask,
    input  logic         mode,
    input  logic         ack,
    output logic         valid,
    output logic [W-1:0] id,
    output logic [N-1:0] pending,
    output logic         any
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t       state_q;
    state_t       state_d;
    logic [W-1:0] id_d;
    logic [W-1:0] last_q;
    logic [W-1:0] last_d;
    logic [N-1:0] pending_d;
    logic [N-1:0] clr;
    logic [N-1:0] elig;
    logic [W-1:0] sel_fix;
    logic [W-1:0] sel_rr;

    assign elig  = pending & ~mask;
    assign any   = |elig;
    assign valid = (state_q == GRANT);

    // Fixed priority: highest eligible index wins.
    always_comb begin
        sel_fix = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (elig[i[W-1:0]]) sel_fix = W'(i);
        end
    end

    // Round-robin: walk downward from last-1, wrapping 0 -> N-1; last itself is
    // visited at distance N, so it is chosen only when nothing else is eligible.
    always_comb begin
        int unsigned c;
        sel_rr = last_q;
        c      = 0;
        for (int unsigned k = N; k >= 1; k--) begin
            c = 32'(last_q) + N - k;
            if (c >= N) c = c - N;
            if (elig[c[W-1:0]]) sel_rr = W'(c);
        end
    end

    // Next state, grant capture, and pending update with set-over-clear priority.
    always_comb begin
        state_d = state_q;
        id_d    = id;
        last_d  = last_q;
        clr     = '0;
        case (state_q)
            IDLE: begin
                if (|elig) begin
                    state_d = GRANT;
                    id_d    = mode ? sel_rr : sel_fix;
                end
            end
            GRANT: begin
                if (ack) begin
                    state_d = IDLE;
                    clr[id] = 1'b1;
                    if (mode) last_d = id;
                end
            end
        endcase
        pending_d = (pending & ~clr) | req;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            id      <= '0;
            last_q  <= '0;
            pending <= '0;
        end else begin
            state_q <= state_d;
            id      <= id_d;
            last_q  <= last_d;
            pending <= pending_d;
        end
    end

endmodule

// File: tb/tb_priority_irq_ctrl.sv
// Bench for priority_irq_ctrl: cycle model compared every cycle on N=8, plus
// directed literal checks on N=8 and N=5 instances.
module tb_priority_irq_ctrl;

    localparam int unsigned N = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req, mask;
    logic       mode, ack;
    logic       valid;
    logic [2:0] id;
    logic [7:0] pending;
    logic       any;

    logic [4:0] req5, mask5;
    logic       mode5, ack5;
    logic       valid5;
    logic [2:0] id5;
    logic [4:0] pending5;
    logic       any5;

    int errors = 0;
    int checks = 0;

    priority_irq_ctrl #(.N(8)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .mask(mask), .mode(mode), .ack(ack),
        .valid(valid), .id(id), .pending(pending), .any(any)
    );

    priority_irq_ctrl #(.N(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .req(req5), .mask(mask5), .mode(mode5), .ack(ack5),
        .valid(valid5), .id(id5), .pending(pending5), .any(any5)
    );

    always #5 clk = ~clk;

    function automatic void chk(string nm, longint unsigned act, longint unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Arbitration rule straight from the requirement text.
    function automatic int pick(logic [7:0] e, logic md, int lst);
        int c;
        if (!md) begin
            for (int i = 7; i >= 0; i--) if (e[i]) return i;
        end else begin
            for (int k = 1; k <= 8; k++) begin
                c = (lst - k + 8) % 8;
                if (e[c]) return c;
            end
        end
        return -1;
    endfunction

    logic [7:0] m_pend;
    logic [7:0] m_clr;
    logic       m_valid;
    int         m_id, m_last, m_p;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend = '0; m_valid = 1'b0; m_id = 0; m_last = 0;
        end else begin
            m_clr = '0;
            if (m_valid) begin
                if (ack) begin
                    m_clr[m_id] = 1'b1;
                    m_valid     = 1'b0;
                    if (mode) m_last = m_id;
                end
            end else begin
                m_p = pick(m_pend & ~mask, mode, m_last);
                if (m_p >= 0) begin
                    m_valid = 1'b1;
                    m_id    = m_p;
                end
            end
            m_pend = (m_pend & ~m_clr) | req;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("valid", 64'(valid), 64'(m_valid));
            chk("id", 64'(id), 64'(m_id));
            chk("pending", 64'(pending), 64'(m_pend));
            chk("any", 64'(any), 64'(|(m_pend & ~mask)));
        end
    end

    int  gq[$];
    logic prev_v;
    always @(negedge clk) begin
        if (!rst_n) prev_v = 1'b0;
        else begin
            if (valid && !prev_v) gq.push_back(int'(id));
            prev_v = valid;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_v(input bit five, input string nm);
        int n = 0;
        while (!(five ? valid5 : valid) && n < 8) begin
            cyc(1);
            n++;
        end
        chk(nm, 64'(five ? valid5 : valid), 64'(1));
    endtask

    int exp31[3] = '{5, 2, 0};
    int exp32[6] = '{7, 1, 0, 7, 1, 0};
    logic [4:0] t5_req[5] = '{5'b10000, 5'b00011, 5'b00000, 5'b10100, 5'b00000};
    int         t5_id[5]  = '{4, 1, 0, 4, 2};
    logic [7:0] stall_req[5] = '{8'h40, 8'h02, 8'h00, 8'h08, 8'h00};

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        req = '0; mask = '0; mode = 1'b0; ack = 1'b0;
        req5 = '0; mask5 = '0; mode5 = 1'b1; ack5 = 1'b0;
        #12;
        chk("rst_valid", 64'(valid), 64'(0));
        chk("rst_id", 64'(id), 64'(0));
        chk("rst_pending", 64'(pending), 64'(0));
        chk("rst_any", 64'(any), 64'(0));
        @(posedge clk); #2;
        rst_n = 1'b1;
        cyc(1);

        // N=5 round-robin, including wrap from 0 to index 4
        for (int i = 0; i < 5; i++) begin
            req5 = t5_req[i];
            cyc(1);
            req5 = '0;
            wait_v(1'b1, $sformatf("n5_valid%0d", i));
            chk($sformatf("n5_id%0d", i), 64'(id5), 64'(t5_id[i]));
            ack5 = 1'b1;
            cyc(1);
            ack5 = 1'b0;
            chk($sformatf("n5_drop%0d", i), 64'(valid5), 64'(0));
        end
        chk("n5_pending_empty", 64'(pending5), 64'(0));

        // fixed priority single pulse
        gq.delete();
        mode = 1'b0; mask = '0; ack = 1'b1; req = 8'b0010_0101;
        cyc(1);
        req = '0;
        cyc(10);
        chk("fp_count", 64'(gq.size()), 64'(3));
        for (int i = 0; i < 3; i++)
            if (i < gq.size()) chk($sformatf("fp_id%0d", i), 64'(gq[i]), 64'(exp31[i]));
        chk("fp_pending", 64'(pending), 64'(0));

        // round-robin with requests held
        gq.delete();
        mode = 1'b1; req = 8'b1000_0011;
        for (int n = 0; n < 40 && gq.size() < 6; n++) cyc(1);
        req = '0;
        cyc(16);
        chk("rr_count_ge6", 64'(gq.size() >= 6), 64'(1));
        for (int i = 0; i < 6; i++)
            if (i < gq.size()) chk($sformatf("rr_id%0d", i), 64'(gq[i]), 64'(exp32[i]));
        chk("rr_pending", 64'(pending), 64'(0));

        // masking
        gq.delete();
        mode = 1'b0; mask = 8'h80; req = 8'h81;
        cyc(1);
        req = '0;
        cyc(6);
        chk("mask_count", 64'(gq.size()), 64'(1));
        if (gq.size() > 0) chk("mask_id0", 64'(gq[0]), 64'(0));
        chk("mask_pending", 64'(pending), 64'(8'h80));
        chk("mask_any", 64'(any), 64'(0));
        chk("mask_idle", 64'(valid), 64'(0));
        ack = 1'b0; mask = '0;
        wait_v(1'b0, "unmask_valid");
        chk("unmask_id", 64'(id), 64'(7));
        mask = 8'h80;
        cyc(2);
        chk("mask_in_grant_valid", 64'(valid), 64'(1));
        chk("mask_in_grant_id", 64'(id), 64'(7));
        ack = 1'b1;
        cyc(1);
        ack = 1'b0; mask = '0;
        chk("mask_ack_valid", 64'(valid), 64'(0));
        chk("mask_ack_pending", 64'(pending), 64'(0));

        // handshake stall while req keeps changing
        req = 8'h10;
        cyc(1);
        req = '0;
        wait_v(1'b0, "stall_valid");
        chk("stall_id", 64'(id), 64'(4));
        for (int i = 0; i < 5; i++) begin
            req = stall_req[i];
            cyc(1);
            chk($sformatf("stall_v%0d", i), 64'(valid), 64'(1));
            chk($sformatf("stall_id%0d", i), 64'(id), 64'(4));
        end
        req = '0; ack = 1'b1;
        cyc(1);
        ack = 1'b0;
        chk("stall_ack_pending", 64'(pending), 64'(8'h4A));
        chk("stall_ack_valid", 64'(valid), 64'(0));
        ack = 1'b1;
        cyc(12);
        ack = 1'b0;
        chk("stall_drain", 64'(pending), 64'(0));

        // async reset mid-grant, then first-edge latching
        req = 8'h08;
        cyc(1);
        req = '0;
        wait_v(1'b0, "ar_valid");
        chk("ar_id", 64'(id), 64'(3));
        #1;
        rst_n = 1'b0;
        #1;
        chk("ar_valid_low", 64'(valid), 64'(0));
        chk("ar_id_zero", 64'(id), 64'(0));
        chk("ar_pending_zero", 64'(pending), 64'(0));
        @(posedge clk); #2;
        rst_n = 1'b1; req = 8'h04;
        cyc(1);
        req = '0;
        chk("post_rst_latch", 64'(pending), 64'(8'h04));
        ack = 1'b1;
        cyc(6);
        ack = 1'b0;
        chk("post_rst_drain", 64'(pending), 64'(0));

        cyc(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
